count_display: RTL

COUNT_DISPLAY -- requirements
Module: count_display

---
 rtl/count_display.sv | 121 ++++++++++++
 1 files changed

// File: rtl/count_display.sv
// Filters a 4-bit count from an asynchronous ripple counter and scans it onto a two-digit display.
// Define COUNT_DISPLAY_LZB_EN to blank the tens digit while the count is below 10.
module count_display #(
    parameter int unsigned REFRESH_DIV = 16
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       Q1,
    input  logic       Q2,
    input  logic       Q3,
    input  logic       Q4,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       upd
);

    localparam logic [15:0] RefreshMax = 16'(REFRESH_DIV - 1);

    typedef enum logic {
        StOnes,
        StTens
    } scan_e;

    logic [3:0]  q_raw;
    logic [3:0]  sync1;
    logic [3:0]  sync2;
    logic [3:0]  sync2_d;
    logic [3:0]  held;
    logic        load;
    logic [15:0] refresh_cnt;
    logic        refresh_wrap;
    scan_e       state_q;
    scan_e       state_d;
    logic [3:0]  ones_dig;
    logic        tens_dig;

    assign q_raw = {Q4, Q3, Q2, Q1};

    // Accept only a value seen on two consecutive synchronized samples, so one-cycle
    // ripple-through states never reach the display.
    assign load = (sync2 == sync2_d) && (sync2 != held);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync1   <= 4'd0;
            sync2   <= 4'd0;
            sync2_d <= 4'd0;
            held    <= 4'd0;
            upd     <= 1'b0;
        end else begin
            sync1   <= q_raw;
            sync2   <= sync1;
            sync2_d <= sync2;
            upd     <= load;
            if (load) begin
                held <= sync2;
            end
        end
    end

    assign refresh_wrap = (refresh_cnt == RefreshMax);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            refresh_cnt <= 16'd0;
            state_q     <= StOnes;
        end else begin
            refresh_cnt <= refresh_wrap ? 16'd0 : refresh_cnt + 16'd1;
            state_q     <= state_d;
        end
    end

    assign tens_dig = (held >= 4'd10);
    assign ones_dig = tens_dig ? (held - 4'd10) : held;

    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b0111111;
            4'd1:    p = 7'b0000110;
            4'd2:    p = 7'b1011011;
            4'd3:    p = 7'b1001111;
            4'd4:    p = 7'b1100110;
            4'd5:    p = 7'b1101101;
            4'd6:    p = 7'b1111101;
            4'd7:    p = 7'b0000111;
            4'd8:    p = 7'b1111111;
            4'd9:    p = 7'b1101111;
            default: p = 7'b0000000;
        endcase
        return p;
    endfunction

    always_comb begin
        state_d = state_q;
        an      = 2'b10;
        seg     = seg_pattern(ones_dig);
        if (refresh_wrap) begin
            state_d = (state_q == StOnes) ? StTens : StOnes;
        end
        case (state_q)
            StOnes: begin
                an  = 2'b10;
                seg = seg_pattern(ones_dig);
            end
            StTens: begin
                an = 2'b01;
`ifdef COUNT_DISPLAY_LZB_EN
                seg = tens_dig ? seg_pattern(4'd1) : 7'b0000000;
`else
                seg = seg_pattern({3'b000, tens_dig});
`endif
            end
            default: begin
                an  = 2'b10;
                seg = seg_pattern(ones_dig);
            end
        endcase
    end

endmodule
